// File: rtl/via_arb_pkg.sv
// Shared types for the VIA register-port arbiter: FSM states, access owner and the
// latched access command.
package via_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    typedef enum logic {
        OWN_A2,
        OWN_HOST
    } owner_t;

    typedef struct packed {
        logic [3:0] addr;
        logic       we;
        logic [7:0] wdata;
    } via_cmd_t;

    localparam via_cmd_t CMD_NONE = '{addr: 4'h0, we: 1'b0, wdata: 8'h00};

endpackage

// File: rtl/via_cmd_slot.sv
// One-deep holding register for an Apple II bus access that arrives while the VIA
// port is busy; a strobe that finds the slot occupied is dropped and flagged.
module via_cmd_slot
    import via_arb_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     load,
    input  via_cmd_t load_cmd,
    input  logic     take,
    input  logic     bypass,
    output logic     full,
    output via_cmd_t cmd,
    output logic     overrun
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full    <= 1'b0;
            cmd     <= CMD_NONE;
            overrun <= 1'b0;
        end else if (take) begin
            // the held entry leaves this cycle, so a coincident strobe refills the slot
            full <= load;
            if (load) begin
                cmd <= load_cmd;
            end
        end else if (load && !bypass) begin
            if (full) begin
                overrun <= 1'b1;
            end else begin
                full <= 1'b1;
                cmd  <= load_cmd;
            end
        end
    end

endmodule

// File: rtl/via_bus_arbiter.sv
// Shares one via6522 register port between the Apple II bus (priority, never stalled)
// and the internal host, issuing at most one VIA access per phi window.
//
//   state   | meaning
//   IDLE    | no access in flight; arbitrate on phi_rising
//   ARMED   | command latched; strobe wen/ren on phi_falling
//   CAPTURE | read issued; wait for VIA read data, then ack owner
module via_bus_arbiter
    import via_arb_pkg::*;
#(
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned HOST_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       phi_rising,
    input  logic       phi_falling,
    input  logic       a2_req,
    input  logic [3:0] a2_addr,
    input  logic       a2_we,
    input  logic [7:0] a2_wdata,
    output logic       a2_ack,
    output logic [7:0] a2_rdata,
    output logic       a2_overrun,
    input  logic       host_req,
    input  logic [3:0] host_addr,
    input  logic       host_we,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic       host_err,
    output logic [7:0] host_rdata,
    output logic [3:0] via_addr,
    output logic       via_wen,
    output logic       via_ren,
    output logic [7:0] via_data_in,
    input  logic [7:0] via_data_out,
    output logic       busy
);

    localparam int unsigned TO_W  = $clog2(HOST_TIMEOUT + 1);
    localparam int unsigned LAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    state_t           state;
    state_t           state_nxt;
    owner_t           owner;
    via_cmd_t         cmd;
    via_cmd_t         a2_cmd_in;
    via_cmd_t         host_cmd_in;
    via_cmd_t         slot_cmd;
    logic             slot_full;
    logic             grant_slot;
    logic             grant_bypass;
    logic             grant_host;
    logic             write_done;
    logic             read_issue;
    logic             capture;
    logic             host_wait;
    logic [LAT_W-1:0] lat_cnt;
    logic [TO_W-1:0]  host_cnt;

    assign a2_cmd_in   = '{addr: a2_addr, we: a2_we, wdata: a2_wdata};
    assign host_cmd_in = '{addr: host_addr, we: host_we, wdata: host_wdata};

    via_cmd_slot u_slot (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (a2_req),
        .load_cmd (a2_cmd_in),
        .take     (grant_slot),
        .bypass   (grant_bypass),
        .full     (slot_full),
        .cmd      (slot_cmd),
        .overrun  (a2_overrun)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_slot   = 1'b0;
        grant_bypass = 1'b0;
        grant_host   = 1'b0;
        write_done   = 1'b0;
        read_issue   = 1'b0;
        capture      = 1'b0;
        via_wen      = 1'b0;
        via_ren      = 1'b0;
        case (state)
            IDLE: begin
                if (phi_rising) begin
                    if (slot_full) begin
                        grant_slot = 1'b1;
                    end else if (a2_req) begin
                        grant_bypass = 1'b1;
                    end else if (host_req) begin
                        grant_host = 1'b1;
                    end
                    if (slot_full || a2_req || host_req) begin
                        state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                if (phi_falling) begin
                    via_wen = cmd.we;
                    via_ren = ~cmd.we;
                    if (cmd.we) begin
                        write_done = 1'b1;
                        state_nxt  = IDLE;
                    end else if (RD_LAT == 1) begin
                        capture   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        read_issue = 1'b1;
                        state_nxt  = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // a host already holding the port is not waiting, so its timer must not run
    assign host_wait = phi_rising && !(state != IDLE && owner == OWN_HOST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= OWN_A2;
            cmd        <= CMD_NONE;
            lat_cnt    <= '0;
            host_cnt   <= '0;
            a2_ack     <= 1'b0;
            a2_rdata   <= 8'h00;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= 8'h00;
        end else begin
            a2_ack   <= 1'b0;
            host_ack <= 1'b0;
            host_err <= 1'b0;

            if (grant_slot || grant_bypass || grant_host) begin
                owner <= grant_host ? OWN_HOST : OWN_A2;
                if (grant_host) begin
                    cmd <= host_cmd_in;
                end else if (grant_slot) begin
                    cmd <= slot_cmd;
                end else begin
                    cmd <= a2_cmd_in;
                end
            end

            if (read_issue) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == CAPTURE && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (write_done || capture) begin
                if (owner == OWN_A2) begin
                    a2_ack <= 1'b1;
                end else begin
                    host_ack <= 1'b1;
                end
            end
            if (capture) begin
                if (owner == OWN_A2) begin
                    a2_rdata <= via_data_out;
                end else begin
                    host_rdata <= via_data_out;
                end
            end

            if (!host_req || grant_host) begin
                host_cnt <= '0;
            end else if (host_wait) begin
                if (host_cnt == TO_W'(HOST_TIMEOUT - 1)) begin
                    host_cnt <= '0;
                    host_ack <= 1'b1;
                    host_err <= 1'b1;
                end else begin
                    host_cnt <= host_cnt + TO_W'(1);
                end
            end
        end
    end

    assign via_addr    = cmd.addr;
    assign via_data_in = cmd.wdata;
    assign busy        = (state != IDLE);

    // the phi generator never produces both edges in one clock
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(phi_rising && phi_falling));
        end
    end

endmodule

// File: tb/tb_via_bus_arbiter.sv
// Bench for via_bus_arbiter: directed scenarios plus random traffic, checked every
// clock against a window-level model of who owns each phi window and when acks land.
module tb_via_bus_arbiter;

    localparam int RD_LAT  = 2;
    localparam int HOST_TO = 4;

    typedef struct packed {
        logic [3:0] addr;
        logic       we;
        logic [7:0] wdata;
    } tb_cmd_t;

    logic       clock;
    logic       reset_n;
    logic       phi_rising;
    logic       phi_falling;
    logic       a2_req;
    logic [3:0] a2_addr;
    logic       a2_we;
    logic [7:0] a2_wdata;
    logic       a2_ack;
    logic [7:0] a2_rdata;
    logic       a2_overrun;
    logic       host_req;
    logic [3:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic       host_err;
    logic [7:0] host_rdata;
    logic [3:0] via_addr;
    logic       via_wen;
    logic       via_ren;
    logic [7:0] via_data_in;
    logic [7:0] via_data_out;
    logic       busy;

    logic [7:0] vmem    [16];
    logic [7:0] ref_mem [16];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ph     = 7;

    tb_cmd_t a2q[$];
    tb_cmd_t w;
    bit      w_a2;
    int      g          = -100;
    int      ack_end    = -95;
    int      a2_ack_c   = -1;
    int      host_ack_c = -1;
    bit      host_err_x = 1'b0;
    bit      ov         = 1'b0;
    int      hw         = 0;
    bit      host_drop  = 1'b0;
    logic [7:0] ex_a2_rd   = 8'h00;
    logic [7:0] ex_host_rd = 8'h00;

    via_bus_arbiter #(
        .RD_LAT       (RD_LAT),
        .HOST_TIMEOUT (HOST_TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .phi_rising   (phi_rising),
        .phi_falling  (phi_falling),
        .a2_req       (a2_req),
        .a2_addr      (a2_addr),
        .a2_we        (a2_we),
        .a2_wdata     (a2_wdata),
        .a2_ack       (a2_ack),
        .a2_rdata     (a2_rdata),
        .a2_overrun   (a2_overrun),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_we      (host_we),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_err     (host_err),
        .host_rdata   (host_rdata),
        .via_addr     (via_addr),
        .via_wen      (via_wen),
        .via_ren      (via_ren),
        .via_data_in  (via_data_in),
        .via_data_out (via_data_out),
        .busy         (busy)
    );

    assign via_data_out = vmem[via_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        int      c;
        bit      granted;
        bit      host_got;
        tb_cmd_t cur_a2;
        c = cyc;
        if (!reset_n) begin
            a2q.delete();
            ov = 1'b0; hw = 0; ex_a2_rd = 8'h00; ex_host_rd = 8'h00;
            g = -100; ack_end = -95; a2_ack_c = -1; host_ack_c = -1;
            chk("rst_via_wen", via_wen, 0);
            chk("rst_via_ren", via_ren, 0);
            chk("rst_via_addr", via_addr, 0);
            chk("rst_via_data_in", via_data_in, 0);
            chk("rst_a2_ack", a2_ack, 0);
            chk("rst_a2_rdata", a2_rdata, 0);
            chk("rst_a2_overrun", a2_overrun, 0);
            chk("rst_host_ack", host_ack, 0);
            chk("rst_host_err", host_err, 0);
            chk("rst_host_rdata", host_rdata, 0);
            chk("rst_busy", busy, 0);
            return;
        end

        if (c == g + 4 && w.we) ref_mem[w.addr] = w.wdata;
        if (c == ack_end && !w.we) begin
            if (w_a2) ex_a2_rd = ref_mem[w.addr];
            else      ex_host_rd = ref_mem[w.addr];
        end

        chk("a2_ack", a2_ack, 32'(c == a2_ack_c));
        chk("host_ack", host_ack, 32'(c == host_ack_c));
        if (c == host_ack_c) chk("host_err", host_err, 32'(host_err_x));
        chk("a2_rdata", a2_rdata, ex_a2_rd);
        chk("host_rdata", host_rdata, ex_host_rd);
        chk("a2_overrun", a2_overrun, 32'(ov));
        chk("busy", busy, 32'(c > g && c < ack_end));
        chk("via_wen", via_wen, 32'(c == g + 4 && w.we));
        chk("via_ren", via_ren, 32'(c == g + 4 && !w.we));
        if (c == g + 4) begin
            chk("via_addr", via_addr, w.addr);
            chk("via_data_in", via_data_in, w.wdata);
        end

        if (via_wen === 1'b1) vmem[via_addr] = via_data_in;

        cur_a2 = '{addr: a2_addr, we: a2_we, wdata: a2_wdata};
        if (phi_rising) begin
            granted  = 1'b0;
            host_got = 1'b0;
            if (a2q.size() > 0) begin
                w = a2q.pop_front(); w_a2 = 1'b1; granted = 1'b1;
                if (a2_req) a2q.push_back(cur_a2);
            end else if (a2_req) begin
                w = cur_a2; w_a2 = 1'b1; granted = 1'b1;
            end else if (host_req) begin
                w = '{addr: host_addr, we: host_we, wdata: host_wdata};
                w_a2 = 1'b0; granted = 1'b1; host_got = 1'b1;
            end
            if (granted) begin
                g = c;
                ack_end = c + 4 + (w.we ? 1 : RD_LAT);
                if (w_a2) a2_ack_c = ack_end;
                else begin
                    host_ack_c = ack_end;
                    host_err_x = 1'b0;
                end
            end
            if (host_req && !host_got) begin
                hw++;
                if (hw == HOST_TO) begin
                    hw = 0;
                    host_ack_c = c + 1;
                    host_err_x = 1'b1;
                end
            end else begin
                hw = 0;
            end
        end else if (a2_req) begin
            if (a2q.size() >= 1) ov = 1'b1;
            else a2q.push_back(cur_a2);
        end
        if (!host_req) hw = 0;
        if (c == host_ack_c) host_drop = 1'b1;
    endtask

    task automatic step();
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
        cyc++;
        ph = (ph + 1) % 8;
        phi_rising  = (ph == 0);
        phi_falling = (ph == 4);
        a2_req = 1'b0;
        if (host_drop) begin
            host_req  = 1'b0;
            host_drop = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_ph(input int p);
        for (int i = 0; i < 8 && ph != p; i++) step();
    endtask

    task automatic a2_strobe(input logic [3:0] a, input logic we, input logic [7:0] d);
        a2_req = 1'b1; a2_addr = a; a2_we = we; a2_wdata = d;
    endtask

    task automatic host_raise(input logic [3:0] a, input logic we, input logic [7:0] d);
        host_req = 1'b1; host_addr = a; host_we = we; host_wdata = d;
    endtask

    initial begin
        reset_n = 1'b0;
        phi_rising = 1'b0; phi_falling = 1'b0;
        a2_req = 1'b0; a2_addr = 4'h0; a2_we = 1'b0; a2_wdata = 8'h00;
        host_req = 1'b0; host_addr = 4'h0; host_we = 1'b0; host_wdata = 8'h00;
        w = '{addr: 4'h0, we: 1'b0, wdata: 8'h00};
        w_a2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vmem[i]    = 8'($urandom_range(0, 255));
            ref_mem[i] = vmem[i];
        end

        run(3);
        reset_n = 1'b1;
        run(4);

        // A2 write strobed ahead of phi_rising
        to_ph(6);
        a2_strobe(4'd3, 1'b1, 8'hFF);
        run(10);

        // host read of a known VIA register value
        vmem[4] = 8'h5A; ref_mem[4] = 8'h5A;
        to_ph(1);
        host_raise(4'd4, 1'b0, 8'h00);
        run(16);

        // host and A2 contend for the same window
        to_ph(7);
        a2_strobe(4'd9, 1'b0, 8'h00);
        host_raise(4'd2, 1'b1, 8'h3C);
        run(24);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0)
                a2_strobe(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if (!host_req && $urandom_range(0, 11) == 0)
                host_raise(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            step();
        end
        run(16);

        // reset while ARMED aborts the access
        to_ph(0);
        a2_strobe(4'd7, 1'b1, 8'hA5);
        run(2);
        reset_n = 1'b0;
        host_req = 1'b0;
        run(3);
        reset_n = 1'b1;
        run(12);

        // overrun: slot fills during a busy window, next strobe is dropped
        to_ph(0);
        a2_strobe(4'd1, 1'b1, 8'h11);
        run(2);
        a2_strobe(4'd2, 1'b1, 8'h22);
        step();
        a2_strobe(4'd5, 1'b1, 8'h55);
        run(20);

        // host starved by A2 every window until it times out
        to_ph(1);
        host_raise(4'd6, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            to_ph(7);
            a2_strobe(4'($urandom_range(0, 15)), 1'b1, 8'($urandom_range(0, 255)));
            step();
        end
        run(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
